// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, port-index type and destination helper
package router_pkg;

   localparam int NPORT           = 3;
   localparam int DEST_W          = 2;
   localparam int TIMEOUT_DEFAULT = 30;

   typedef logic [DEST_W-1:0] port_idx_t;

   localparam port_idx_t DEST_INVALID = 2'd3;

   // A destination is usable only if it names an existing output port
   function automatic logic is_valid_dest(input port_idx_t d);
      return (int'(d) < NPORT);
   endfunction

endpackage

// File: rtl/router_port_timer.sv
// rtl/router_port_timer.sv - per-port stall counter producing a one-cycle FIFO flush pulse
module router_port_timer
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk1,
   input  logic reset,
   input  logic i_empty,
   input  logic i_read,
   output logic o_soft_reset
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   logic [7:0] r_cnt;
   logic       r_soft_reset;

   // Count consecutive valid-but-unread cycles; flush and restart when the limit is reached
   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b0;
      end else if (i_read || i_empty) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b0;
      end else if (r_cnt == LAST_CNT) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b1;
      end else begin
         r_cnt        <= r_cnt + 8'd1;
         r_soft_reset <= 1'b0;
      end
   end

   assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - router destination select, write steering and port supervisor (timeout gated by ROUTER_SYNC_TIMEOUT_EN)
module router_sync
   import router_pkg::*;
#(
   parameter int NPORT   = router_pkg::NPORT,
   parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             detect_add,
   input  logic [1:0]       data_in,
   input  logic             write_enb_reg,
   input  logic [NPORT-1:0] full,
   input  logic [NPORT-1:0] empty,
   input  logic [NPORT-1:0] read_enb,
   output logic [NPORT-1:0] write_enb,
   output logic             fifo_full,
   output logic [NPORT-1:0] vld_out,
   output logic [NPORT-1:0] soft_reset,
   output logic             dest_err
);

   port_idx_t        r_dest;
   logic             r_dest_err;
   logic [NPORT-1:0] w_write_enb;
   logic             w_fifo_full;
   logic             w_dest_ok;

   // Latch the header's destination; flag headers that address no port
   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         r_dest     <= DEST_INVALID;
         r_dest_err <= 1'b0;
      end else begin
         if (detect_add) begin
            r_dest <= data_in;
         end
         r_dest_err <= detect_add && (data_in == DEST_INVALID);
      end
   end

   assign w_dest_ok = is_valid_dest(r_dest);

   // Steer the single write strobe and select the matching full flag; invalid destination discards
   always_comb begin
      w_write_enb = '0;
      w_fifo_full = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (w_dest_ok && (r_dest == port_idx_t'(i))) begin
            w_write_enb[i] = write_enb_reg;
            w_fifo_full    = full[i];
         end
      end
   end

   assign write_enb = w_write_enb;
   assign fifo_full = w_fifo_full;
   assign vld_out   = ~empty;
   assign dest_err  = r_dest_err;

`ifdef ROUTER_SYNC_TIMEOUT_EN
   genvar g;
   for (g = 0; g < NPORT; g++) begin : g_timer
      router_port_timer #(
         .TIMEOUT (TIMEOUT)
      ) u_timer (
         .clk1         (clk1),
         .reset        (reset),
         .i_empty      (empty[g]),
         .i_read       (read_enb[g]),
         .o_soft_reset (soft_reset[g])
      );
   end
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
   logic w_unused_read;
   assign w_unused_read = ^read_enb;
   assign soft_reset    = '0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// tb/tb_router_sync.sv - directed self-checking bench for router_sync
module tb_router_sync;

   logic       clk1;
   logic       reset;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic [2:0] full;
   logic [2:0] empty;
   logic [2:0] read_enb;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic [2:0] vld_out;
   logic [2:0] soft_reset;
   logic       dest_err;

   int n_checks = 0;
   int n_errors = 0;

   router_sync #(
      .NPORT   (3),
      .TIMEOUT (30)
   ) dut (
      .clk1          (clk1),
      .reset         (reset),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .full          (full),
      .empty         (empty),
      .read_enb      (read_enb),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset),
      .dest_err      (dest_err)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic set_dest(input logic [1:0] d);
      detect_add = 1'b1;
      data_in    = d;
      tick();
      detect_add = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      detect_add    = 1'b0;
      data_in       = 2'd0;
      write_enb_reg = 1'b1;
      full          = 3'b111;
      empty         = 3'b010;
      read_enb      = 3'b000;
      repeat (2) tick();
      #1;
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL reset_write_enb got %b want 000", write_enb); end
      n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
      n_checks++; if (dest_err !== 1'b0) begin n_errors++; $display("FAIL reset_dest_err got %b want 0", dest_err); end
      n_checks++; if (soft_reset !== 3'b000) begin n_errors++; $display("FAIL reset_soft_reset got %b want 000", soft_reset); end
      n_checks++; if (vld_out !== 3'b101) begin n_errors++; $display("FAIL reset_vld_out got %b want 101", vld_out); end
      reset = 1'b1;
      empty = 3'b111;
      tick();
      #1;
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL post_reset_blocked got %b want 000", write_enb); end
      write_enb_reg = 1'b0;
   endtask

   task automatic test_routing();
      set_dest(2'd1);
      write_enb_reg = 1'b1;
      for (int i = 0; i < 4; i++) begin
         full = (i % 2 == 0) ? 3'b010 : 3'b101;
         #1;
         n_checks++; if (write_enb !== 3'b010) begin n_errors++; $display("FAIL route1_write_enb cyc %0d got %b want 010", i, write_enb); end
         n_checks++; if (fifo_full !== (i % 2 == 0)) begin n_errors++; $display("FAIL route1_fifo_full cyc %0d got %b want %b", i, fifo_full, (i % 2 == 0)); end
         tick();
      end
      write_enb_reg = 1'b0;
      #1;
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL route1_idle got %b want 000", write_enb); end
      full = 3'b000;
   endtask

   task automatic test_all_ports();
      logic [2:0] exp_we;
      for (int p = 0; p < 3; p++) begin
         set_dest(2'(p));
         write_enb_reg = 1'b1;
         full   = 3'b000;
         exp_we = 3'b001 << p;
         #1;
         n_checks++; if (write_enb !== exp_we) begin n_errors++; $display("FAIL port%0d_write_enb got %b want %b", p, write_enb, exp_we); end
         full = exp_we;
         #1;
         n_checks++; if (fifo_full !== 1'b1) begin n_errors++; $display("FAIL port%0d_fifo_full got %b want 1", p, fifo_full); end
         full = ~exp_we;
         #1;
         n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL port%0d_other_full got %b want 0", p, fifo_full); end
         write_enb_reg = 1'b0;
         tick();
      end
      full = 3'b000;
   endtask

   task automatic test_invalid_dest();
      detect_add = 1'b1;
      data_in    = 2'd3;
      #1;
      n_checks++; if (dest_err !== 1'b0) begin n_errors++; $display("FAIL dest_err_early got %b want 0", dest_err); end
      tick();
      detect_add = 1'b0;
      n_checks++; if (dest_err !== 1'b1) begin n_errors++; $display("FAIL dest_err_pulse got %b want 1", dest_err); end
      write_enb_reg = 1'b1;
      full          = 3'b111;
      #1;
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL invalid_write_enb got %b want 000", write_enb); end
      n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL invalid_fifo_full got %b want 0", fifo_full); end
      tick();
      n_checks++; if (dest_err !== 1'b0) begin n_errors++; $display("FAIL dest_err_width got %b want 0", dest_err); end
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL invalid_write_enb2 got %b want 000", write_enb); end
      write_enb_reg = 1'b0;
      full          = 3'b000;
   endtask

   task automatic test_back_to_back();
      set_dest(2'd0);
      detect_add    = 1'b1;
      data_in       = 2'd2;
      write_enb_reg = 1'b1;
      #1;
      n_checks++; if (write_enb !== 3'b001) begin n_errors++; $display("FAIL b2b_old_dest got %b want 001", write_enb); end
      tick();
      detect_add = 1'b0;
      #1;
      n_checks++; if (write_enb !== 3'b100) begin n_errors++; $display("FAIL b2b_new_dest got %b want 100", write_enb); end
      write_enb_reg = 1'b0;
      tick();
   endtask

   task automatic test_vld_out();
      logic [2:0] pats [4];
      pats = '{3'b000, 3'b101, 3'b010, 3'b110};
      for (int i = 0; i < 4; i++) begin
         empty = pats[i];
         #1;
         n_checks++; if (vld_out !== ~pats[i]) begin n_errors++; $display("FAIL vld_out pat %0d got %b want %b", i, vld_out, ~pats[i]); end
      end
      empty = 3'b111;
      tick();
   endtask

`ifdef ROUTER_SYNC_TIMEOUT_EN
   task automatic test_timeout();
      logic [2:0] exp_sr;
      empty    = 3'b011;
      read_enb = 3'b000;
      for (int k = 1; k <= 61; k++) begin
         tick();
         exp_sr = (k == 30 || k == 60) ? 3'b100 : 3'b000;
         n_checks++; if (soft_reset !== exp_sr) begin n_errors++; $display("FAIL timeout2 tick %0d got %b want %b", k, soft_reset, exp_sr); end
      end
      empty = 3'b111;
      tick();
   endtask

   task automatic test_read_suppress();
      logic [2:0] exp_sr;
      empty    = 3'b110;
      read_enb = 3'b000;
      for (int k = 1; k <= 59; k++) begin
         read_enb = (k == 29) ? 3'b001 : 3'b000;
         tick();
         exp_sr = (k == 59) ? 3'b001 : 3'b000;
         n_checks++; if (soft_reset !== exp_sr) begin n_errors++; $display("FAIL read_suppress tick %0d got %b want %b", k, soft_reset, exp_sr); end
      end
      read_enb = 3'b000;
      empty    = 3'b111;
      tick();
   endtask

   task automatic test_simultaneous();
      empty    = 3'b000;
      read_enb = 3'b000;
      repeat (29) tick();
      n_checks++; if (soft_reset !== 3'b000) begin n_errors++; $display("FAIL simul_early got %b want 000", soft_reset); end
      tick();
      n_checks++; if (soft_reset !== 3'b111) begin n_errors++; $display("FAIL simul_pulse got %b want 111", soft_reset); end
      empty = 3'b111;
      tick();
      n_checks++; if (soft_reset !== 3'b000) begin n_errors++; $display("FAIL simul_end got %b want 000", soft_reset); end
   endtask
`else
   task automatic test_macro_off();
      int bad;
      bad      = 0;
      empty    = 3'b011;
      read_enb = 3'b000;
      for (int k = 1; k <= 100; k++) begin
         tick();
         n_checks++; if (soft_reset !== 3'b000) begin n_errors++; bad++; if (bad < 4) $display("FAIL macro_off tick %0d got %b want 000", k, soft_reset); end
      end
      empty = 3'b111;
      tick();
   endtask
`endif

   task automatic test_async_reset();
      set_dest(2'd1);
      write_enb_reg = 1'b1;
      full          = 3'b111;
      #1;
      n_checks++; if (write_enb !== 3'b010) begin n_errors++; $display("FAIL pre_reset_write_enb got %b want 010", write_enb); end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL async_write_enb got %b want 000", write_enb); end
      n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL async_fifo_full got %b want 0", fifo_full); end
      tick();
      reset = 1'b1;
      tick();
      n_checks++; if (write_enb !== 3'b000) begin n_errors++; $display("FAIL after_reset_blocked got %b want 000", write_enb); end
      set_dest(2'd0);
      #1;
      n_checks++; if (write_enb !== 3'b001) begin n_errors++; $display("FAIL after_reset_route got %b want 001", write_enb); end
      write_enb_reg = 1'b0;
      full          = 3'b000;
      tick();
   endtask

   initial begin
      test_reset();
      test_routing();
      test_all_ports();
      test_invalid_dest();
      test_back_to_back();
      test_vld_out();
`ifdef ROUTER_SYNC_TIMEOUT_EN
      test_timeout();
      test_read_suppress();
      test_simultaneous();
`else
      test_macro_off();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/router_sync.md
# router_sync

Destination-select and output-port supervisor for the 1x3 router. Sits between `router_fsm`, the three output FIFOs and the three downstream readers. It:
- latches the destination address from the header byte;
- steers the FSM's single write strobe to exactly one output FIFO;
- returns that FIFO's full flag to the FSM;
- flags each non-empty FIFO as valid to its reader;
- soft-resets any FIFO whose reader stops draining it.

## Interface
Parameters:
- `NPORT`, 3, number of output FIFOs/ports (fixed at 3 for this router).
- `TIMEOUT`, 30, consecutive unread-valid cycles before a port is soft-reset (range 2..255).

Ports:
- `clk1`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `detect_add`  in  1  from `router_fsm`: header byte is on `data_in` this cycle.
- `data_in`  in  2  destination address field of the header (0..2 valid, 3 invalid).
- `write_enb_reg`  in  1  from `router_fsm`: write current byte to the selected FIFO.
- `full`  in  3  per-FIFO full flags.
- `empty`  in  3  per-FIFO empty flags.
- `read_enb`  in  3  per-port read strobes from downstream readers.
- `write_enb`  out  3  one-hot FIFO write enables.
- `fifo_full`  out  1  full flag of the selected FIFO, to `router_fsm`.
- `vld_out`  out  3  per-port data-valid flags to the readers.
- `soft_reset`  out  3  per-FIFO single-cycle flush pulse.
- `dest_err`  out  1  single-cycle pulse: header carried an invalid address.

## Operation
- **Destination register `dest_reg` (2 bits):**
  - resets to 3 (invalid);
  - loads `data_in` on every clock where `detect_add`=1;
  - holds otherwise.
- **`dest_err`:** registered; 1 for exactly the cycle after a `detect_add` with `data_in`=3, else 0.
- **`write_enb` (combinational):**
  - bit `dest_reg` = `write_enb_reg` when `dest_reg` is 0..2;
  - all bits 0 when `dest_reg`=3, so the packet is silently discarded.
- **`fifo_full` (combinational):** `full[dest_reg]` when `dest_reg` is 0..2; 0 when `dest_reg`=3, so the FSM never stalls on a discarded packet.
- **`vld_out[i]` (combinational):** = ~`empty[i]`.
- **Timeout counter per port `i`:**
  - increments when `vld_out[i]`=1 and `read_enb[i]`=0;
  - clears to 0 when `read_enb[i]`=1 or `empty[i]`=1.
- **Timeout expiry:** when the counter equals `TIMEOUT`-1 and the increment condition holds, the counter clears and registered `soft_reset[i]` goes to 1 for one cycle.
- **Port independence:** ports time out independently; simultaneous expiries on several ports all pulse in the same cycle.
- **Soft-reset pulse does not clear `dest_reg`.** A write to a port in the same cycle its `soft_reset` is high is the FIFO's concern; `router_sync` still drives `write_enb`.

## Timing
- **Reset values:** `dest_reg`=3, all counters 0, `soft_reset`=0, `dest_err`=0. Hence `write_enb`=0 and `fifo_full`=0; `vld_out` follows `empty`.
- **Header to write latency:** a header sampled at edge N steers writes asserted from edge N onward. The header byte itself, if written in the `detect_add` cycle, goes to the *previous* `dest_reg` (registered select). `router_fsm` writes the header in the cycle after `detect_add`.
- **`detect_add` and `write_enb_reg` in the same cycle:** the write uses the old `dest_reg`.
- **Soft-reset edge:** `soft_reset[i]` rises on the edge following the `TIMEOUT`-th consecutive unread-valid cycle. A `read_enb[i]` in that final cycle suppresses the pulse.
- **Reset mid-packet:** asynchronous clear of all state. Outputs return to reset values immediately, without waiting for a clock.

## Configuration
- `ROUTER_SYNC_TIMEOUT_EN` defined: timeout counters and `soft_reset` behave as above.
- Not defined:
  - counters are not instantiated;
  - `soft_reset` is tied to 3'b000;
  - `TIMEOUT` is ignored;
  - all other behaviour is unchanged.

## Structure
- **Shared package `router_pkg`:**
  - `NPORT`;
  - destination address width (2);
  - `DEST_INVALID`=2'd3;
  - default `TIMEOUT`;
  - the port-index type, shared with `router_fsm` and the FIFOs.
- **Sub-module `router_port_timer`:** one counter plus `soft_reset` flop per port, instantiated `NPORT` times under `ROUTER_SYNC_TIMEOUT_EN`.
- **Top level:** destination register, write steering, full mux and `dest_err` stay in the top module.

## Test plan
- **Routing:** `detect_add`=1, `data_in`=1, then `write_enb_reg`=1 for 4 cycles -> `write_enb`=3'b010 for those 4 cycles; `fifo_full` mirrors `full[1]`.
- **Invalid destination:** `detect_add` with `data_in`=3 -> `dest_err`=1 for one cycle; subsequent `write_enb_reg`=1 gives `write_enb`=0 and `fifo_full`=0 even with `full`=3'b111.
- **Timeout:** `empty[2]`=0, `read_enb[2]`=0 held, `TIMEOUT`=30 -> `soft_reset`=3'b100 for exactly one cycle, after the 30th cycle. Holding the condition 30 more cycles yields a second pulse.
- **Read suppresses timeout:** `read_enb[0]`=1 pulsed on cycle 29 of an unread-valid run -> no `soft_reset[0]`; the counter restarts from 0.
- **Async reset:** `reset` driven low mid-packet between clock edges -> `write_enb`=0 and `dest_reg`=3 immediately. After release, writes are blocked until the next `detect_add`.
- **Macro off:** with `ROUTER_SYNC_TIMEOUT_EN` undefined, repeat the timeout stimulus -> `soft_reset` stays 0 for 100 cycles.
